// File: rtl/app_pkg.sv
// rtl/app_pkg.sv - framer states, transmitter status codes and the CRC-8 reference function
package app_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CRC,
    WAIT_AVAIL,
    START,
    WAIT_RES,
    REPORT
  } framer_state_t;

  localparam logic [1:0] ERR_BUSY = 2'b11;
  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_NAK  = 2'b01;
  localparam logic [1:0] ERR_FAIL = 2'b10;

  localparam logic [7:0] HEADER_BYTE = 8'h3c;

  // MSB-first CRC-8, init 0, no reflection, no final XOR
  function automatic logic [7:0] crc8(input logic [31:0] data, input logic [7:0] poly);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 31; i >= 0; i--) begin
      if (c[7] ^ data[i]) c = {c[6:0], 1'b0} ^ poly;
      else                c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/crc8_serial.sv
// rtl/crc8_serial.sv - bit-serial CRC-8, one message bit per enabled cycle, MSB first
module crc8_serial
  import app_pkg::*;
#(
  parameter logic [7:0] POLY = 8'h07
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic [7:0] r_crc;

  always_ff @(posedge clk) begin
    if (rst || start) begin
      r_crc <= 8'h00;
    end else if (en) begin
      r_crc <= {r_crc[6:0], 1'b0} ^ ({8{r_crc[7] ^ bit_in}} & POLY);
    end
  end

  assign crc = r_crc;

endmodule

// File: rtl/packet_framer.sv
// rtl/packet_framer.sv - frames a 32-bit word as {header, payload, crc8} and drives the transmit handshake
// Optional resend on NAK/error/timeout is enabled by defining FRAMER_RETRY_EN.
module packet_framer
  import app_pkg::*;
#(
  parameter int          N_PKT       = 48,
  parameter logic [7:0]  HEADER      = HEADER_BYTE,
  parameter logic [7:0]  CRC_POLY    = 8'h07,
  parameter int          MAX_RETRY   = 3,
  parameter logic [31:0] TIMEOUT_CYC = 32'h000f_ffff
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N_PKT-1:0] data2send,
  output logic             start_tx,
  input  logic             avail_tx,
  input  logic [1:0]       err_code_tx,
  output logic             done,
  output logic             fail,
  output logic [1:0]       retry_cnt
);

  framer_state_t    r_state;
  logic [31:0]      r_payload;
  logic [31:0]      r_to_cnt;
  logic [4:0]       r_bit_cnt;
  logic             r_first;
  logic             r_in_ready;
  logic             r_start_tx;
  logic             r_done;
  logic             r_fail;
  logic [N_PKT-1:0] r_data;

  logic       w_accept;
  logic       w_crc_en;
  logic       w_crc_bit;
  logic [7:0] w_crc;
  logic       w_res_valid;
  logic       w_timeout;

`ifdef FRAMER_RETRY_EN
  localparam logic [1:0] LP_MAX_RETRY = 2'(MAX_RETRY);
  logic [1:0] r_retry;
  assign retry_cnt = r_retry;
`else
  assign retry_cnt = 2'b00;
`endif

  assign w_accept    = (r_state == IDLE) && in_valid;
  assign w_crc_en    = (r_state == CRC);
  assign w_crc_bit   = r_payload[5'd31 - r_bit_cnt];
  // the first WAIT_RES cycle still carries the transmitter's stale status
  assign w_res_valid = !r_first && (err_code_tx != ERR_BUSY);
  assign w_timeout   = (r_to_cnt == TIMEOUT_CYC - 32'd1);

  crc8_serial #(
    .POLY(CRC_POLY)
  ) u_crc (
    .clk   (clk),
    .rst   (rst),
    .start (w_accept),
    .en    (w_crc_en),
    .bit_in(w_crc_bit),
    .crc   (w_crc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_payload  <= 32'h0;
      r_to_cnt   <= 32'h0;
      r_bit_cnt  <= 5'd0;
      r_first    <= 1'b0;
      r_in_ready <= 1'b1;
      r_start_tx <= 1'b0;
      r_done     <= 1'b0;
      r_fail     <= 1'b0;
      r_data     <= '0;
`ifdef FRAMER_RETRY_EN
      r_retry    <= 2'b00;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_payload  <= in_data;
            r_bit_cnt  <= 5'd0;
            r_in_ready <= 1'b0;
            r_state    <= CRC;
          end
        end
        CRC: begin
          r_bit_cnt <= r_bit_cnt + 5'd1;
          if (r_bit_cnt == 5'd31) r_state <= WAIT_AVAIL;
        end
        WAIT_AVAIL: begin
          // reloading on resends is harmless: payload and CRC are unchanged
          r_data <= N_PKT'({HEADER, r_payload, w_crc});
          if (avail_tx) begin
            r_start_tx <= 1'b1;
            r_state    <= START;
          end
        end
        START: begin
          r_start_tx <= 1'b0;
          r_first    <= 1'b1;
          r_to_cnt   <= 32'h0;
          r_state    <= WAIT_RES;
        end
        WAIT_RES: begin
          r_first  <= 1'b0;
          r_to_cnt <= r_to_cnt + 32'd1;
          if (w_res_valid && (err_code_tx == ERR_OK)) begin
            r_done  <= 1'b1;
            r_state <= REPORT;
          end else if (w_res_valid || w_timeout) begin
`ifdef FRAMER_RETRY_EN
            if (r_retry < LP_MAX_RETRY) begin
              r_retry <= r_retry + 2'd1;
              r_state <= WAIT_AVAIL;
            end else begin
              r_fail  <= 1'b1;
              r_state <= REPORT;
            end
`else
            r_fail  <= 1'b1;
            r_state <= REPORT;
`endif
          end
        end
        REPORT: begin
          r_done     <= 1'b0;
          r_fail     <= 1'b0;
          r_in_ready <= 1'b1;
`ifdef FRAMER_RETRY_EN
          r_retry    <= 2'b00;
`endif
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign data2send = r_data;
  assign start_tx  = r_start_tx;
  assign done      = r_done;
  assign fail      = r_fail;

endmodule
